// File: rtl/mefdispensador_pkg.sv
// Shared definitions for the banknote dispenser: note codes, note values and FSM states.
// The note codes match the ones decoded by the banknote acceptor.
package mefdispensador_pkg;

  localparam logic [3:0] NOTA2     = 4'b1000;
  localparam logic [3:0] NOTA5     = 4'b1001;
  localparam logic [3:0] NOTA10    = 4'b1010;
  localparam logic [3:0] NOTA_ERRO = 4'b1011;

  localparam logic [3:0] VALOR2  = 4'd2;
  localparam logic [3:0] VALOR5  = 4'd5;
  localparam logic [3:0] VALOR10 = 4'd10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ENVIA = 3'd2,
    DONE  = 3'd3,
    ERRO  = 3'd4
  } estado_t;

  // Face value of a note code; anything that is not a payable note is worth nothing.
  function automatic logic [3:0] valor_nota(input logic [3:0] codigo);
    logic [3:0] v;
    v = 4'd0;
    case (codigo)
      NOTA2:   v = VALOR2;
      NOTA5:   v = VALOR5;
      NOTA10:  v = VALOR10;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mefdispensador_temporizador_ack.sv
// Ack timeout counter: counts ENVIA cycles without ack and flags the cycle in which the
// count reaches TIMEOUT.
module temporizador_ack #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic estouro
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flag in the same cycle the increment would reach TIMEOUT, so the note is shown exactly TIMEOUT cycles.
  assign estouro = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mefdispensador.sv
// Banknote dispenser FSM: pays a requested amount note by note (R$5, R$10, R$2, greedy)
// over a valid/ack handshake, with an ack timeout and detection of unpayable amounts.
module mefdispensador
  import mefdispensador_pkg::*;
#(
  parameter int W       = 5,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] valor,
  input  logic         ack,
  output logic [3:0]   nota,
  output logic         nota_vld,
  output logic         busy,
  output logic         done,
  output logic         erro,
  output logic [W-1:0] restante
);

  estado_t    estado;
  estado_t    prox_estado;
  logic [3:0] nota_sel;
  logic       tmr_clr;
  logic       tmr_en;
  logic       estouro;

  assign tmr_clr = (estado != ENVIA);
  assign tmr_en  = (estado == ENVIA) && !ack;

  temporizador_ack #(
    .TIMEOUT(TIMEOUT)
  ) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .estouro(estouro)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= IDLE;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      IDLE: begin
        if (start) prox_estado = CALC;
      end
      CALC: begin
        if (restante == '0) begin
          prox_estado = DONE;
        end else if (restante[0] && (restante < W'(5))) begin
          prox_estado = ERRO;
        end else begin
          prox_estado = ENVIA;
        end
      end
      ENVIA: begin
        // An ack in the timeout cycle still completes the note.
        if (ack) begin
          prox_estado = CALC;
        end else if (estouro) begin
          prox_estado = ERRO;
        end
      end
      DONE: begin
        prox_estado = IDLE;
      end
      ERRO: begin
        if (!start) prox_estado = IDLE;
      end
      default: begin
        prox_estado = IDLE;
      end
    endcase
  end

  // Greedy choice: an odd amount needs one R$5 first, after which everything stays even.
  always_comb begin
    nota_sel = NOTA2;
    if (restante[0]) begin
      nota_sel = NOTA5;
    end else if (restante >= W'(10)) begin
      nota_sel = NOTA10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      restante <= '0;
      nota     <= '0;
    end else begin
      if ((estado == IDLE) && start) begin
        restante <= valor;
      end else if ((estado == ENVIA) && ack) begin
        restante <= restante - W'(valor_nota(nota));
      end

      if (prox_estado == ENVIA) begin
        if (estado == CALC) nota <= nota_sel;
      end else if (prox_estado == ERRO) begin
        nota <= NOTA_ERRO;
      end else begin
        nota <= '0;
      end
    end
  end

  assign nota_vld = (estado == ENVIA);
  assign busy     = (estado != IDLE);
  assign done     = (estado == DONE);
  assign erro     = (estado == ERRO);

endmodule
